// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: per-frame pong sequencer (PAD, BALL, COLL, SCORE); define PONG_AI_RIGHT_EN for an AI right paddle
module pong_game_ctrl #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_LX    = 16,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  input  logic       btn_start,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_l_y,
  output logic [9:0] pad_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       serving,
  output logic       game_over,
  output logic       busy,
  output logic       update_done
);
  localparam int PAD_RX = H_RES - PADDLE_LX - PADDLE_W;
  localparam int PAD_MAX = V_RES - PADDLE_H;
  localparam int BALL_XMAX = H_RES - BALL_SIZE;
  localparam int BALL_YMAX = V_RES - BALL_SIZE;
  localparam logic signed [10:0] BX0 = 11'((H_RES - BALL_SIZE) / 2);
  localparam logic signed [10:0] BY0 = 11'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0] PAD0 = 10'((V_RES - PADDLE_H) / 2);
  localparam logic [15:0] SERVE_LOAD = 16'(SERVE_FRAMES);
  typedef enum logic [1:0] {SERVE, PLAY, GAMEOVER} mode_t;
  typedef enum logic [2:0] {IDLE, PAD, BALL, COLL, SCORE} phase_t;
  mode_t mode;
  phase_t phase;
  logic signed [10:0] bx, by;
  logic dir_x, dir_y;
  logic [15:0] serve_cnt;
  logic r_up, r_dn;
  logic hit_l, hit_r;
  int bxi, byi, pli, pri;
  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
    int t;
    t = int'(y) + ((dn && !up) ? PADDLE_SPEED : 0) - ((up && !dn) ? PADDLE_SPEED : 0);
    return 10'(t < 0 ? 0 : (t > PAD_MAX ? PAD_MAX : t));
  endfunction
`ifdef PONG_AI_RIGHT_EN
  int ai_diff;
  logic unused_btn_r;
  assign unused_btn_r = btn_r_up ^ btn_r_dn;
  // right paddle chases the ball centre, holding once within one step of it
  always_comb begin
    ai_diff = (byi + BALL_SIZE / 2) - (pri + PADDLE_H / 2);
    r_up = ai_diff < -PADDLE_SPEED;
    r_dn = ai_diff > PADDLE_SPEED;
  end
`else
  assign r_up = btn_r_up;
  assign r_dn = btn_r_dn;
`endif
  // paddle overlap tests use the positions left by the BALL phase
  always_comb begin
    bxi = int'(bx);
    byi = int'(by);
    pli = int'(pad_l_y);
    pri = int'(pad_r_y);
    hit_l = !dir_x && bxi < PADDLE_LX + PADDLE_W && bxi + BALL_SIZE > PADDLE_LX &&
            byi + BALL_SIZE > pli && byi < pli + PADDLE_H;
    hit_r = dir_x && bxi + BALL_SIZE > PAD_RX && bxi < PAD_RX + PADDLE_W &&
            byi + BALL_SIZE > pri && byi < pri + PADDLE_H;
  end
  assign ball_x = bx[9:0];
  assign ball_y = by[9:0];
  assign serving = mode == SERVE;
  assign game_over = mode == GAMEOVER;
  assign busy = phase != IDLE;
  assign update_done = phase == SCORE;
  // frame sequencer and game state; dir_x/dir_y high mean right/down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= IDLE;
      mode <= SERVE;
      bx <= BX0;
      by <= BY0;
      pad_l_y <= PAD0;
      pad_r_y <= PAD0;
      score_l <= '0;
      score_r <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
      serve_cnt <= SERVE_LOAD;
    end else begin
      case (phase)
        IDLE: begin
          if (mode == GAMEOVER) begin
            if (btn_start) begin
              mode <= SERVE;
              bx <= BX0;
              by <= BY0;
              pad_l_y <= PAD0;
              pad_r_y <= PAD0;
              score_l <= '0;
              score_r <= '0;
              dir_x <= 1'b1;
              dir_y <= 1'b1;
              serve_cnt <= SERVE_LOAD;
            end
          end else if (frame_tick) phase <= PAD;
        end
        PAD: begin
          pad_l_y <= pad_step(pad_l_y, btn_l_up, btn_l_dn);
          pad_r_y <= pad_step(pad_r_y, r_up, r_dn);
          phase <= BALL;
        end
        BALL: begin
          if (mode == PLAY) begin
            bx <= 11'(bxi + (dir_x ? BALL_SPEED : -BALL_SPEED));
            by <= 11'(byi + (dir_y ? BALL_SPEED : -BALL_SPEED));
          end
          phase <= COLL;
        end
        COLL: begin
          if (mode == PLAY) begin
            if (byi <= 0) begin
              by <= '0;
              dir_y <= 1'b1;
            end else if (byi >= BALL_YMAX) begin
              by <= 11'(BALL_YMAX);
              dir_y <= 1'b0;
            end
            if (hit_l) begin
              bx <= 11'(PADDLE_LX + PADDLE_W);
              dir_x <= 1'b1;
            end else if (hit_r) begin
              bx <= 11'(PAD_RX - BALL_SIZE);
              dir_x <= 1'b0;
            end
          end
          phase <= SCORE;
        end
        SCORE: begin
          phase <= IDLE;
          if (mode == PLAY && (bxi <= 0 || bxi >= BALL_XMAX)) begin
            bx <= BX0;
            by <= BY0;
            dir_x <= bxi > 0;
            serve_cnt <= SERVE_LOAD;
            if (bxi <= 0) score_r <= score_r + 4'd1;
            else score_l <= score_l + 4'd1;
            mode <= (((bxi <= 0) ? score_r : score_l) == 4'(WIN_SCORE - 1)) ? GAMEOVER : SERVE;
          end else if (mode == SERVE) begin
            serve_cnt <= serve_cnt - 16'd1;
            if (serve_cnt <= 16'd1) mode <= PLAY;
          end
        end
        default: phase <= IDLE;
      endcase
    end
  end
endmodule
